sistema_area: RTL and testbench

- Area-optimized proof-of-work miner built around the UCR micro-hash.
- Searches 32-bit nonces upward from 0 for a fixed 96-bit payload until the 24-bit hash meets a target.
- Uses a single iterative hash datapath: one message-expansion word or one compression round per clock.
- Top-level mining block; the throughput-optimized variant is a separate block.

---
 rtl/sistema_area.sv | 192 +++++++++++++++++++
 tb/tb_sistema_area.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sistema_area.sv
// sistema_area: area-optimized proof-of-work miner around the UCR micro-hash.
// A single iterative datapath expands one message word or runs one
// compression round per clock; nonces are searched upward from 0 until
// H0 and H1 of the 24-bit hash are both below the target.
module sistema_area (
  input  logic        clk,
  input  logic        reset,
  input  logic [95:0] payload,
  input  logic        active,
  input  logic [7:0]  target,
  output logic        terminado,
  output logic [31:0] nonceOut,
  output logic [23:0] hashOut
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    EXPAND = 3'd2,
    ROUND  = 3'd3,
    FINAL  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [7:0] H0_INIT = 8'h01;
  localparam logic [7:0] H1_INIT = 8'h89;
  localparam logic [7:0] H2_INIT = 8'hFE;

  state_t      state;
  state_t      next_state;
  logic [7:0]  w [0:31];
  logic [4:0]  idx;
  logic [31:0] nonce;
  logic [7:0]  h0, h1, h2;
  logic [7:0]  a, b, c;

  logic [7:0]  k;
  logic [7:0]  x;
  logic [7:0]  c_next;
  logic [7:0]  sum0, sum1, sum2;
  logic        pass;
  logic        last_step;

  // Message expansion rule for one word.
  function automatic logic [7:0] expand_word(input logic [7:0] w3,
                                             input logic [7:0] w9,
                                             input logic [7:0] w14);
    return w3 | (w9 ^ w14);
  endfunction

  // Round constant/mix selection, final sums and target comparison.
  always_comb begin
    k = 8'h99;
    x = 8'h00;
    if (idx <= 5'd16) begin
      k = 8'h99;
      x = a ^ b;
    end else begin
      k = 8'hA1;
      x = a ^ b ^ c;
    end
    c_next    = x + k + w[idx];
    sum0      = h0 + a;
    sum1      = h1 + b;
    sum2      = h2 + c;
    pass      = (sum0 < target) && (sum1 < target);
    last_step = (idx == 5'd31);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; dropping active in any search state aborts to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (active) next_state = LOAD;
        else        next_state = IDLE;
      end
      LOAD: begin
        if (!active) next_state = IDLE;
        else         next_state = EXPAND;
      end
      EXPAND: begin
        if (!active)       next_state = IDLE;
        else if (last_step) next_state = ROUND;
        else               next_state = EXPAND;
      end
      ROUND: begin
        if (!active)       next_state = IDLE;
        else if (last_step) next_state = FINAL;
        else               next_state = ROUND;
      end
      FINAL: begin
        if (!active)  next_state = IDLE;
        else if (pass) next_state = DONE;
        else          next_state = LOAD;
      end
      DONE: begin
        if (!active) next_state = IDLE;
        else         next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath, nonce counter and registered results.
  // terminado is raised on the first DONE cycle, one clock after the winning
  // nonce/hash are captured, so the outputs are already stable when it asserts.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= 5'd0;
      nonce     <= 32'd0;
      h0        <= 8'h00;
      h1        <= 8'h00;
      h2        <= 8'h00;
      a         <= 8'h00;
      b         <= 8'h00;
      c         <= 8'h00;
      terminado <= 1'b0;
      nonceOut  <= 32'd0;
      hashOut   <= 24'd0;
      for (int i = 0; i < 32; i++) begin
        w[i] <= 8'h00;
      end
    end else begin
      case (state)
        IDLE: begin
          if (active) begin
            nonce     <= 32'd0;
            terminado <= 1'b0;
            nonceOut  <= 32'd0;
            hashOut   <= 24'd0;
          end
        end
        LOAD: begin
          for (int i = 0; i < 12; i++) begin
            w[i] <= payload[95 - 8*i -: 8];
          end
          for (int j = 0; j < 4; j++) begin
            w[12 + j] <= nonce[31 - 8*j -: 8];
          end
          h0  <= H0_INIT;
          h1  <= H1_INIT;
          h2  <= H2_INIT;
          a   <= H0_INIT;
          b   <= H1_INIT;
          c   <= H2_INIT;
          idx <= 5'd16;
        end
        EXPAND: begin
          w[idx] <= expand_word(w[idx - 5'd3], w[idx - 5'd9], w[idx - 5'd14]);
          idx    <= idx + 5'd1;
        end
        ROUND: begin
          a   <= b ^ c;
          b   <= {c[3:0], 4'h0};
          c   <= c_next;
          idx <= idx + 5'd1;
        end
        FINAL: begin
          h0 <= sum0;
          h1 <= sum1;
          h2 <= sum2;
          if (active) begin
            if (pass) begin
              nonceOut <= nonce;
              hashOut  <= {sum0, sum1, sum2};
            end else begin
              nonce <= nonce + 32'd1;
            end
          end
        end
        DONE: begin
          if (active) terminado <= 1'b1;
          else        terminado <= 1'b0;
        end
        default: begin
          terminado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sistema_area.sv
// Self-checking bench for sistema_area: stimulus pushes expected winners into
// a scoreboard queue, a monitor pops and compares on each terminado rise.
module tb_sistema_area;

  logic        clk = 1'b0;
  logic        reset;
  logic [95:0] payload;
  logic        active;
  logic [7:0]  target;
  logic        terminado;
  logic [31:0] nonceOut;
  logic [23:0] hashOut;

  sistema_area dut (
    .clk       (clk),
    .reset     (reset),
    .payload   (payload),
    .active    (active),
    .target    (target),
    .terminado (terminado),
    .nonceOut  (nonceOut),
    .hashOut   (hashOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] n;
    logic [23:0] h;
    logic [7:0]  t;
    int          start;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  logic term_prev = 1'b0;

  localparam logic [95:0] BENCH_PAYLOAD = 96'h397d9f2f40ca9e6c6b1f3324;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference hash written straight from the message/round rules.
  function automatic logic [23:0] ref_hash(input logic [95:0] p, input logic [31:0] n);
    logic [7:0]   w [32];
    logic [127:0] blk;
    logic [7:0]   ra, rb, rc, rx, rk, na;
    blk = {p, n};
    for (int i = 0; i < 16; i++) w[i] = blk[127 - 8*i -: 8];
    for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
    ra = 8'h01; rb = 8'h89; rc = 8'hFE;
    for (int i = 0; i < 32; i++) begin
      if (i <= 16) begin rk = 8'h99; rx = ra ^ rb; end
      else         begin rk = 8'hA1; rx = ra ^ rb ^ rc; end
      na = rb ^ rc;
      rb = rc << 4;
      rc = rx + rk + w[i];
      ra = na;
    end
    return {8'h01 + ra, 8'h89 + rb, 8'hFE + rc};
  endfunction

  // Smallest winning nonce for payload/target, searched up to a limit.
  task automatic ref_search(input logic [95:0] p, input logic [7:0] t, input int limit,
                            output int n, output logic [23:0] h);
    n = -1;
    h = 24'd0;
    for (int i = 0; i < limit; i++) begin
      logic [23:0] hh;
      hh = ref_hash(p, i);
      if (hh[23:16] < t && hh[15:8] < t) begin
        n = i;
        h = hh;
        break;
      end
    end
  endtask

  // Monitor: every rising terminado must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (terminado === 1'b1 && term_prev === 1'b0) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: terminado rose with nonceOut=%0h hashOut=%0h", nonceOut, hashOut);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("nonceOut", 64'(nonceOut), 64'(e.n));
          chk("hashOut", 64'(hashOut), 64'(e.h));
          chk("latency", 64'(cyc - e.start), 64'(51 + 50 * int'(e.n)));
          chk("h0_below_target", 64'(hashOut[23:16] < e.t), 64'd1);
          chk("h1_below_target", 64'(hashOut[15:8] < e.t), 64'd1);
        end
        done_cnt++;
      end
      term_prev = terminado;
    end
  end

  // Full search: raise active, await winner, check hold and release from DONE.
  task automatic run_search(input logic [95:0] p, input logic [7:0] t, input int n, input logic [23:0] h);
    exp_t e;
    int   d0;
    int   waited;
    logic [31:0] sn;
    logic [23:0] sh;
    @(negedge clk);
    payload = p;
    target  = t;
    active  = 1'b1;
    e.n = n; e.h = h; e.t = t; e.start = cyc + 1;
    q.push_back(e);
    d0 = done_cnt;
    @(negedge clk);
    chk("clear_on_start", {31'd0, terminado, nonceOut, 8'd0, hashOut} , 64'd0);
    waited = 1;
    while (done_cnt == d0 && waited < 51 + 50 * n + 20) begin
      @(negedge clk);
      waited++;
    end
    if (done_cnt == d0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no terminado after %0d cycles, expected nonce %0h", waited, n);
      q.delete();
      active = 1'b0;
      repeat (2) @(negedge clk);
      return;
    end
    sn = nonceOut;
    sh = hashOut;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_stable", {31'd0, terminado, nonceOut, 8'd0, hashOut}, {31'd0, 1'b1, sn, 8'd0, sh});
    end
    active = 1'b0;
    @(negedge clk);
    chk("release_terminado", 64'(terminado), 64'd0);
    chk("release_retained", {nonceOut, 8'd0, hashOut}, {sn, 8'd0, sh});
    @(negedge clk);
  endtask

  initial begin
    int          n;
    logic [23:0] h;
    logic [95:0] p;
    logic [7:0]  t;

    reset   = 1'b1;
    active  = 1'b1;
    payload = BENCH_PAYLOAD;
    target  = 8'h0a;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {31'd0, terminado, nonceOut, 8'd0, hashOut}, 64'd0);
    active = 1'b0;
    reset  = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", {31'd0, terminado, dut.nonce}, 64'd0);

    // Easy target: first nonce whose H0/H1 are not 8'hFF wins.
    ref_search(BENCH_PAYLOAD, 8'hFF, 64, n, h);
    run_search(BENCH_PAYLOAD, 8'hFF, n, h);

    // Randomized payloads with generous targets.
    for (int r = 0; r < 6; r++) begin
      p = {$urandom, $urandom, $urandom};
      t = 8'($urandom_range(8'h60, 8'hFF));
      ref_search(p, t, 400, n, h);
      if (n >= 0) run_search(p, t, n, h);
    end

    // Abort 30 cycles into a search, then restart from nonce 0.
    p = {$urandom, $urandom, $urandom};
    t = 8'h60;
    ref_search(p, t, 400, n, h);
    @(negedge clk);
    payload = p;
    target  = t;
    active  = 1'b1;
    repeat (30) @(negedge clk);
    active = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle", 64'(terminado), 64'd0);
    if (n >= 0) run_search(p, t, n, h);

    // Unsolvable target: 1000 cycles, 19 completed attempts, never done.
    @(negedge clk);
    payload = BENCH_PAYLOAD;
    target  = 8'h00;
    active  = 1'b1;
    repeat (1000) @(negedge clk);
    chk("unsolvable_nonce", 64'(dut.nonce), 64'd19);
    chk("unsolvable_terminado", 64'(terminado), 64'd0);
    active = 1'b0;
    repeat (2) @(negedge clk);

    // Bench vector with the real difficulty target.
    ref_search(BENCH_PAYLOAD, 8'h0a, 1200, n, h);
    if (n >= 0) run_search(BENCH_PAYLOAD, 8'h0a, n, h);
    else $display("note: bench vector winner lies beyond the cycle budget; skipped");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
